scene_compositor: RTL and testbench

SCENE_COMPOSITOR -- requirements
Module: scene_compositor

---
 rtl/scene_compositor_if.sv | 28 ++
 rtl/scene_compositor.sv | 220 ++++++++++++++++++++++
 tb/tb_scene_compositor.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scene_compositor_if.sv
// Scene compositor bus: per-layer colour and game events in, composited pixel and scene status out.
// The master drives the video/game inputs; the slave (the compositor) drives pixel/scene/lives.
interface scene_compositor_if #(
  parameter int NUM_LAYERS = 8,
  parameter int COLOR_W    = 8
);
  logic [NUM_LAYERS*COLOR_W-1:0] layer_color;
  logic                          video_on;
  logic                          frame_start;
  logic                          action_pulse;
  logic                          life_lost;
  logic                          life_gain;
  logic                          blend_mode;
  logic [COLOR_W-1:0]            pixel_out;
  logic [1:0]                    scene;
  logic [3:0]                    lives;
  logic                          scene_change;

  modport master (
    output layer_color, video_on, frame_start, action_pulse, life_lost, life_gain, blend_mode,
    input  pixel_out, scene, lives, scene_change
  );

  modport slave (
    input  layer_color, video_on, frame_start, action_pulse, life_lost, life_gain, blend_mode,
    output pixel_out, scene, lives, scene_change
  );
endinterface

// File: rtl/scene_compositor.sv
// Scene FSM with frame-aligned commits, lives counter, and a registered layer compositor (1-clock latency, no backpressure).
// Define SCENE_TIMEOUT_EN to add the frame counter and the GAME_OVER -> HIGH_SCORE -> TITLE timeouts.
module scene_compositor #(
  parameter int                    NUM_LAYERS     = 8,
  parameter int                    COLOR_W        = 8,
  parameter int                    LIVES_INIT     = 4,
  parameter int                    LIVES_MAX      = 9,
  parameter int                    TIMEOUT_FRAMES = 180,
  parameter logic [NUM_LAYERS-1:0] TITLE_MASK     = '1,
  parameter logic [NUM_LAYERS-1:0] PLAY_MASK      = '1,
  parameter logic [NUM_LAYERS-1:0] OVER_MASK      = '1,
  parameter logic [NUM_LAYERS-1:0] HISCORE_MASK   = '1
) (
  input  logic              clk,
  input  logic              reset,
  scene_compositor_if.slave bus
);

  if (NUM_LAYERS < 2 || NUM_LAYERS > 16 || LIVES_MAX < LIVES_INIT || LIVES_MAX > 15 ||
      TIMEOUT_FRAMES < 1) begin : g_bad_params
    $error("scene_compositor: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    SC_TITLE   = 2'd0,
    SC_PLAY    = 2'd1,
    SC_OVER    = 2'd2,
    SC_HISCORE = 2'd3
  } scene_e;

  scene_e             scene_q, scene_d;
  scene_e             req_scene_q, req_scene_d;
  logic               req_vld_q, req_vld_d;
  logic               scene_change_q, scene_change_d;
  logic [3:0]         lives_q, lives_d;
  logic [COLOR_W-1:0] pixel_q, pixel_d;

  logic               new_req_vld;
  scene_e             new_req_scene;
  logic               eff_req_vld;
  scene_e             eff_req_scene;
  logic               commit;
  logic               lose_one;
  logic               gain_one;

  assign lose_one = bus.life_lost && !bus.life_gain;
  assign gain_one = bus.life_gain && !bus.life_lost;

`ifdef SCENE_TIMEOUT_EN
  localparam int FC_W = $clog2(TIMEOUT_FRAMES + 1);

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            timeout_hit;

  assign timeout_hit = (frame_cnt_q == FC_W'(TIMEOUT_FRAMES));
`endif

  // Event -> requested scene; an action outranks a timeout arriving in the same cycle.
  always_comb begin
    new_req_vld   = 1'b0;
    new_req_scene = SC_TITLE;
    case (scene_q)
      SC_TITLE: begin
        if (bus.action_pulse) begin
          new_req_vld   = 1'b1;
          new_req_scene = SC_PLAY;
        end
      end
      SC_PLAY: begin
        if (lose_one && lives_q == 4'd1) begin
          new_req_vld   = 1'b1;
          new_req_scene = SC_OVER;
        end
      end
      SC_OVER: begin
        if (bus.action_pulse) begin
          new_req_vld   = 1'b1;
          new_req_scene = SC_TITLE;
        end
`ifdef SCENE_TIMEOUT_EN
        else if (timeout_hit) begin
          new_req_vld   = 1'b1;
          new_req_scene = SC_HISCORE;
        end
`endif
      end
      SC_HISCORE: begin
        if (bus.action_pulse) begin
          new_req_vld   = 1'b1;
          new_req_scene = SC_TITLE;
        end
`ifdef SCENE_TIMEOUT_EN
        else if (timeout_hit) begin
          new_req_vld   = 1'b1;
          new_req_scene = SC_TITLE;
        end
`endif
      end
      default: begin
        new_req_vld   = 1'b0;
        new_req_scene = SC_TITLE;
      end
    endcase
  end

  // A held request wins over anything new until it has been committed.
  assign eff_req_vld   = req_vld_q || new_req_vld;
  assign eff_req_scene = req_vld_q ? req_scene_q : new_req_scene;
  assign commit        = bus.frame_start && eff_req_vld;

  always_comb begin
    scene_d        = scene_q;
    scene_change_d = 1'b0;
    req_vld_d      = eff_req_vld;
    req_scene_d    = eff_req_scene;
    lives_d        = lives_q;

    if (scene_q == SC_PLAY) begin
      if (lose_one && lives_q != 4'd0) begin
        lives_d = lives_q - 4'd1;
      end else if (gain_one && lives_q < 4'(LIVES_MAX)) begin
        lives_d = lives_q + 4'd1;
      end
    end

    if (commit) begin
      scene_d        = eff_req_scene;
      scene_change_d = 1'b1;
      req_vld_d      = 1'b0;
      req_scene_d    = SC_TITLE;
      if (eff_req_scene == SC_PLAY) begin
        lives_d = 4'(LIVES_INIT);
      end
    end
  end

`ifdef SCENE_TIMEOUT_EN
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (commit) begin
      frame_cnt_d = '0;
    end else if (bus.frame_start && (scene_q == SC_OVER || scene_q == SC_HISCORE) &&
                 frame_cnt_q < FC_W'(TIMEOUT_FRAMES)) begin
      frame_cnt_d = frame_cnt_q + FC_W'(1);
    end
  end
`endif

  logic [NUM_LAYERS-1:0] layer_en;
  logic [COLOR_W-1:0]    prio_c;
  logic [COLOR_W-1:0]    or_c;
  logic [COLOR_W-1:0]    lay_c;

  always_comb begin
    case (scene_q)
      SC_TITLE:   layer_en = TITLE_MASK;
      SC_PLAY:    layer_en = PLAY_MASK;
      SC_OVER:    layer_en = OVER_MASK;
      SC_HISCORE: layer_en = HISCORE_MASK;
      default:    layer_en = '0;
    endcase
  end

  // Walk from the top layer down so the lowest-index opaque layer is the last one written.
  always_comb begin
    prio_c = '0;
    or_c   = '0;
    lay_c  = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      lay_c = bus.layer_color[k*COLOR_W +: COLOR_W];
      if (layer_en[k]) begin
        or_c = or_c | lay_c;
        if (lay_c != '0) begin
          prio_c = lay_c;
        end
      end
    end
    if (!bus.video_on) begin
      pixel_d = '0;
    end else if (bus.blend_mode) begin
      pixel_d = or_c;
    end else begin
      pixel_d = prio_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scene_q        <= SC_TITLE;
      req_vld_q      <= 1'b0;
      req_scene_q    <= SC_TITLE;
      scene_change_q <= 1'b0;
      lives_q        <= 4'(LIVES_INIT);
      pixel_q        <= '0;
    end else begin
      scene_q        <= scene_d;
      req_vld_q      <= req_vld_d;
      req_scene_q    <= req_scene_d;
      scene_change_q <= scene_change_d;
      lives_q        <= lives_d;
      pixel_q        <= pixel_d;
    end
  end

`ifdef SCENE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`endif

  assign bus.pixel_out    = pixel_q;
  assign bus.scene        = scene_q;
  assign bus.lives        = lives_q;
  assign bus.scene_change = scene_change_q;

endmodule

// File: tb/tb_scene_compositor.sv
// Directed scene/lives sequence plus random pixel and event traffic, checked against a cycle-level game model.
module tb_scene_compositor;
  localparam int NL = 8;
  localparam int CW = 8;
  localparam int LI = 4;
  localparam int LM = 9;
  localparam int TO = 180;
  localparam logic [NL-1:0] TM = 8'hFF;
  localparam logic [NL-1:0] PM = 8'hF5;
  localparam logic [NL-1:0] OM = 8'h3C;
  localparam logic [NL-1:0] HM = 8'hC3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  scene_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

  scene_compositor #(
    .NUM_LAYERS(NL), .COLOR_W(CW), .LIVES_INIT(LI), .LIVES_MAX(LM), .TIMEOUT_FRAMES(TO),
    .TITLE_MASK(TM), .PLAY_MASK(PM), .OVER_MASK(OM), .HISCORE_MASK(HM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Game model: scene 0..3, lives, pending target (-1 = none), frames seen in the current scene.
  int m_scene = 0;
  int m_lives = LI;
  int m_pend = -1;
  int m_frames = 0;
  int m_sc = 0;
  int m_pix = 0;
  bit rnd_pix = 1'b1;
  int col[NL];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mask_of(input int s);
    case (s)
      0: return int'(TM);
      1: return int'(PM);
      2: return int'(OM);
      default: return int'(HM);
    endcase
  endfunction

  function automatic int compose(input int s, input bit blend, input bit von);
    int m;
    int acc;
    int opaque[$];
    m = mask_of(s);
    acc = 0;
    if (!von) return 0;
    for (int k = 0; k < NL; k++) begin
      if (((m >> k) & 1) == 1) begin
        acc = acc | col[k];
        if (col[k] != 0) opaque.push_back(col[k]);
      end
    end
    if (blend) return acc;
    if (opaque.size() > 0) return opaque[0];
    return 0;
  endfunction

  task automatic step(input bit fs, input bit act, input bit lost, input bit gain);
    int req;
    int target;
    int ns;
    int nl;
    int np;
    int nf;
    int nsc;
    int npix;
    bus.frame_start  = fs;
    bus.action_pulse = act;
    bus.life_lost    = lost;
    bus.life_gain    = gain;
    if (rnd_pix) begin
      for (int k = 0; k < NL; k++)
        col[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      bus.video_on   = ($urandom_range(0, 3) != 0);
      bus.blend_mode = $urandom_range(0, 1);
    end
    for (int k = 0; k < NL; k++) bus.layer_color[k*CW +: CW] = col[k][CW-1:0];

    req = -1;
    case (m_scene)
      0: if (act) req = 1;
      1: if (lost && !gain && m_lives == 1) req = 2;
      2: begin
        if (act) req = 0;
`ifdef SCENE_TIMEOUT_EN
        else if (m_frames >= TO) req = 3;
`endif
      end
      default: begin
        if (act) req = 0;
`ifdef SCENE_TIMEOUT_EN
        else if (m_frames >= TO) req = 0;
`endif
      end
    endcase
    target = (m_pend >= 0) ? m_pend : req;
    ns = m_scene;
    nl = m_lives;
    nf = m_frames;
    nsc = 0;
    npix = compose(m_scene, bus.blend_mode, bus.video_on);
    if (m_scene == 1) begin
      if (lost && !gain && m_lives > 0) nl = m_lives - 1;
      else if (gain && !lost && m_lives < LM) nl = m_lives + 1;
    end
    if (fs && target >= 0) begin
      ns = target;
      nsc = 1;
      np = -1;
      nf = 0;
      if (target == 1) nl = LI;
    end else begin
      np = target;
      if (fs && m_scene >= 2 && m_frames < TO) nf = m_frames + 1;
    end
    if (reset) begin
      ns = 0; nl = LI; np = -1; nf = 0; nsc = 0; npix = 0;
    end

    @(posedge clk);
    #1;
    m_scene = ns; m_lives = nl; m_pend = np; m_frames = nf; m_sc = nsc; m_pix = npix;
    check("scene", 32'(bus.scene), m_scene);
    check("lives", 32'(bus.lives), m_lives);
    check("scene_change", 32'(bus.scene_change), m_sc);
    check("pixel_out", 32'(bus.pixel_out), m_pix);
    bus.frame_start  = 1'b0;
    bus.action_pulse = 1'b0;
    bus.life_lost    = 1'b0;
    bus.life_gain    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    bus.layer_color  = '0;
    bus.video_on     = 1'b0;
    bus.frame_start  = 1'b0;
    bus.action_pulse = 1'b0;
    bus.life_lost    = 1'b0;
    bus.life_gain    = 1'b0;
    bus.blend_mode   = 1'b0;

    // Reset state
    reset = 1'b1;
    idle(2);
    check("rst_scene", 32'(bus.scene), 0);
    check("rst_lives", 32'(bus.lives), LI);
    check("rst_pixel", 32'(bus.pixel_out), 0);
    reset = 1'b0;
    idle(3);

    // Action mid-frame, commit at a frame_start 100 cycles later
    step(0, 1, 0, 0);
    idle(99);
    check("title_hold", 32'(bus.scene), 0);
    step(1, 0, 0, 0);
    check("play_commit", 32'(bus.scene), 1);
    check("play_sc_pulse", 32'(bus.scene_change), 1);
    check("play_lives", 32'(bus.lives), 4);
    step(0, 0, 0, 0);
    check("sc_one_cycle", 32'(bus.scene_change), 0);

    // Lose all lives; GAME_OVER commits only at the next frame_start
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      check("lives_dec", 32'(bus.lives), 3 - i);
    end
    idle(3);
    check("over_wait_frame", 32'(bus.scene), 1);
    step(0, 0, 1, 0);
    check("lives_floor", 32'(bus.lives), 0);
    step(1, 0, 0, 0);
    check("over_commit", 32'(bus.scene), 2);

    // Back to TITLE, then PLAY again
    step(0, 1, 0, 0);
    idle(2);
    step(1, 0, 0, 0);
    check("title_commit", 32'(bus.scene), 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    check("play_again", 32'(bus.scene), 1);
    check("play_again_lives", 32'(bus.lives), LI);

    // Saturation and simultaneous gain/loss
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      check("lives_inc", 32'(bus.lives), (5 + i > LM) ? LM : 5 + i);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    check("lives_at5", 32'(bus.lives), 5);
    step(0, 0, 1, 1);
    check("lives_both", 32'(bus.lives), 5);

    // Compositing with fixed layers; layer 1 is masked off in PLAY
    rnd_pix = 1'b0;
    for (int k = 0; k < NL; k++) col[k] = 0;
    col[1] = 8'h03;
    col[2] = 8'hE0;
    col[5] = 8'h1C;
    bus.video_on = 1'b1;
    bus.blend_mode = 1'b0;
    step(0, 0, 0, 0);
    check("pix_prio", 32'(bus.pixel_out), 8'hE0);
    bus.blend_mode = 1'b1;
    check("pix_latency", 32'(bus.pixel_out), 8'hE0);
    step(0, 0, 0, 0);
    check("pix_or", 32'(bus.pixel_out), 8'hFC);
    bus.video_on = 1'b0;
    step(0, 0, 0, 0);
    check("pix_blank", 32'(bus.pixel_out), 8'h00);
    rnd_pix = 1'b1;

    // Drain lives into GAME_OVER
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    check("over_again", 32'(bus.scene), 2);

`ifdef SCENE_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      step(1, 0, 0, 0);
      idle(2);
    end
    check("over_before_to", 32'(bus.scene), 2);
    step(1, 0, 0, 0);
    check("hiscore_commit", 32'(bus.scene), 3);
    for (int i = 0; i < TO; i++) begin
      step(1, 0, 0, 0);
      idle(2);
    end
    check("hiscore_before_to", 32'(bus.scene), 3);
    step(1, 0, 0, 0);
    check("hiscore_to_title", 32'(bus.scene), 0);
`else
    for (int i = 0; i < TO + 20; i++) begin
      step(1, 0, 0, 0);
      idle(1);
    end
    check("no_timeout", 32'(bus.scene), 2);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    check("over_to_title", 32'(bus.scene), 0);
`endif

    // Reset beats a pending PLAY request and a simultaneous frame_start
    step(0, 1, 0, 0);
    reset = 1'b1;
    step(1, 0, 0, 0);
    check("rst_pend_scene", 32'(bus.scene), 0);
    check("rst_pend_sc", 32'(bus.scene_change), 0);
    reset = 1'b0;
    step(1, 0, 0, 0);
    check("rst_cleared_req", 32'(bus.scene), 0);
    check("rst_cleared_sc", 32'(bus.scene_change), 0);

    // Random event traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
